insn_fetch_decode: RTL
======================

INSN_FETCH_DECODE -- requirements
Module: insn_fetch_decode

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: run  input  1  level; 1 = keep fetching, 0 = stop at next instruction boundary.
REQ-005 SHALL have port: pc  input  8  current program-counter register value.
REQ-006 SHALL have port: ram_rdata  input  8  RAM read data, valid one cycle after ram_rd_en.
REQ-007 SHALL have port: insn_done  input  1  from bus_control, marks the last cycle of the executing instruction.
REQ-008 SHALL have port: ram_rd_en  output  1  RAM fetch-read strobe.
REQ-009 SHALL have port: ram_addr  output  8  fetch address.
REQ-010 SHALL have port: pc_inc  output  1  one-cycle PC increment pulse.
REQ-011 SHALL have port: insn_en  output  ISA_INSN_COUNT  one-hot decoded instruction, to bus_control.
REQ-012 SHALL have port: reg_num  output  3  encoded register or immediate field, to bus_control.
REQ-013 SHALL have port: illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-014 SHALL use the instruction format: bits[7:3] opcode, bits[2:0] reg_num/immediate.
REQ-015 SHALL map opcode value k (0 <= k < ISA_INSN_COUNT) to insn_en[k], with the ISA_* indices taken from the shared header.
REQ-016 SHALL treat opcode >= ISA_INSN_COUNT as illegal.
REQ-017 SHALL implement a five-state FSM: IDLE, FETCH, WAIT, EXEC, NEXT.
REQ-018 SHALL transition IDLE->FETCH when run=1 and otherwise stay in IDLE.
REQ-019 SHALL transition FETCH->WAIT unconditionally.
REQ-020 SHALL transition WAIT->EXEC unconditionally, latching ram_rdata into the 8-bit instruction register at the end of WAIT.
REQ-021 SHALL stay in EXEC while insn_done=0 and transition EXEC->NEXT on insn_done=1.
REQ-022 SHALL, for an illegal opcode, transition EXEC->NEXT after exactly one cycle with insn_en=0 and illegal=1 for that cycle, ignoring insn_done.
REQ-023 SHALL transition NEXT->FETCH if run=1 and NEXT->IDLE otherwise.
REQ-024 SHALL assert ram_rd_en=1 and ram_addr=pc only in FETCH, and drive ram_rd_en=0 and ram_addr=0 in all other states.
REQ-025 SHALL drive insn_en and reg_num from the instruction register only in EXEC, held constant for the whole EXEC residency, and drive both to 0 in all other states.
REQ-026 SHALL assert pc_inc=1 only in NEXT, so the PC has updated before the next FETCH samples pc.
REQ-027 SHALL take exactly 4 cycles per instruction when insn_done arrives on the first EXEC cycle: FETCH, WAIT, EXEC, NEXT.
REQ-028 SHALL ignore insn_done outside EXEC.
REQ-029 SHALL complete the current instruction through NEXT when run falls mid-instruction, then park in IDLE.
REQ-030 SHALL wrap pc from 0xFF to 0x00 without special handling; wrap is the PC register's job.
REQ-031 SHALL assert at most one insn_en bit in any cycle.

Reset
REQ-032 SHALL, while rst_n=0, force state IDLE, instruction register 0x00, and ram_rd_en, ram_addr, pc_inc, insn_en, reg_num and illegal all 0, immediately and independent of clk.
REQ-033 SHALL abandon any in-flight instruction when reset asserts mid-operation, with no pc_inc issued.
REQ-034 SHALL leave the first FETCH one cycle after rst_n rises with run=1.

Structure
REQ-035 SHALL take ISA_INSN_COUNT, the ISA_* opcode indices and the field positions from the shared param.vh; no local copies.
REQ-036 SHALL use FSM state encodings local to the module.
REQ-037 SHALL place the opcode-to-one-hot decode in a combinational sub-module, insn_decoder (inputs opcode; outputs insn_en, illegal_op).

Verification
REQ-038 SHALL cover: reset release, run=1, pc=0x10, ram_rdata=0x08|3 (opcode 1, reg 3), insn_done on first EXEC -> ram_rd_en at cycle 1, insn_en[1]=1 and reg_num=3 at cycle 3, pc_inc at cycle 4, next FETCH at cycle 5.
REQ-039 SHALL cover: insn_done delayed 1 cycle (two-cycle instruction) -> insn_en held 2 cycles, then pc_inc, 5-cycle period.
REQ-040 SHALL cover: ram_rdata=0xF8 with ISA_INSN_COUNT < 31 -> insn_en=0, illegal=1 for one cycle, pc_inc next cycle.
REQ-041 SHALL cover: run dropped during EXEC -> instruction finishes, pc_inc issued, FSM in IDLE, no further ram_rd_en.
REQ-042 SHALL cover: rst_n pulsed low during EXEC -> all outputs 0 asynchronously, no pc_inc, refetch at same pc after release.
REQ-043 SHALL cover: insn_done=1 held high during FETCH/WAIT -> ignored; EXEC still lasts at least one cycle.

Source files
------------

// File: rtl/insn_fetch_decode_pkg.sv
// Shared ISA definitions for the fetch/decode slice: opcode indices, instruction
// field positions and small field-extraction helpers.
package insn_fetch_decode_pkg;

   localparam int unsigned ISA_INSN_COUNT = 16;

   localparam int unsigned ISA_NOP = 0;
   localparam int unsigned ISA_LDI = 1;
   localparam int unsigned ISA_LD  = 2;
   localparam int unsigned ISA_ST  = 3;
   localparam int unsigned ISA_ADD = 4;
   localparam int unsigned ISA_SUB = 5;
   localparam int unsigned ISA_AND = 6;
   localparam int unsigned ISA_OR  = 7;
   localparam int unsigned ISA_XOR = 8;
   localparam int unsigned ISA_SHL = 9;
   localparam int unsigned ISA_SHR = 10;
   localparam int unsigned ISA_JMP = 11;
   localparam int unsigned ISA_JZ  = 12;
   localparam int unsigned ISA_JNZ = 13;
   localparam int unsigned ISA_IN  = 14;
   localparam int unsigned ISA_OUT = 15;

   localparam int unsigned INSN_W  = 8;
   localparam int unsigned OPC_MSB = 7;
   localparam int unsigned OPC_LSB = 3;
   localparam int unsigned REG_MSB = 2;
   localparam int unsigned REG_LSB = 0;
   localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
   localparam int unsigned REG_W   = REG_MSB - REG_LSB + 1;

   function automatic logic [OPC_W-1:0] insn_opcode(input logic [INSN_W-1:0] insn);
      return insn[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [REG_W-1:0] insn_reg(input logic [INSN_W-1:0] insn);
      return insn[REG_MSB:REG_LSB];
   endfunction

endpackage

// File: rtl/insn_fetch_decode_decoder.sv
// Combinational opcode decoder: one-hot enable for defined opcodes, flag for the rest.
module insn_decoder
   import insn_fetch_decode_pkg::*;
(
   input  logic [OPC_W-1:0]          opcode,
   output logic [ISA_INSN_COUNT-1:0] insn_en,
   output logic                      illegal_op
);

   always_comb begin
      insn_en = '0;
      for (int unsigned k = 0; k < ISA_INSN_COUNT; k++) begin
         if (opcode == OPC_W'(k)) begin
            insn_en[k] = 1'b1;
         end
      end
      illegal_op = (32'(opcode) >= ISA_INSN_COUNT);
   end

endmodule

// File: rtl/insn_fetch_decode.sv
// Instruction fetch/decode sequencer: fetches one byte per instruction from RAM,
// decodes it and holds the decoded enables until bus_control signals completion.
module insn_fetch_decode
   import insn_fetch_decode_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      run,
   input  logic [7:0]                pc,
   input  logic [7:0]                ram_rdata,
   input  logic                      insn_done,
   output logic                      ram_rd_en,
   output logic [7:0]                ram_addr,
   output logic                      pc_inc,
   output logic [ISA_INSN_COUNT-1:0] insn_en,
   output logic [REG_W-1:0]          reg_num,
   output logic                      illegal
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StExec,
      StNext
   } state_e;

   state_e              state_q, state_d;
   logic [INSN_W-1:0]   ir_q, ir_d;
   logic [ISA_INSN_COUNT-1:0] dec_en;
   logic                dec_illegal;

   insn_decoder u_insn_decoder (
      .opcode     (insn_opcode(ir_q)),
      .insn_en    (dec_en),
      .illegal_op (dec_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      unique case (state_q)
         StIdle:  if (run) state_d = StFetch;
         StFetch: state_d = StWait;
         StWait: begin
            state_d = StExec;
            ir_d    = ram_rdata;
         end
         // An undefined opcode never sees insn_done; it retires after one cycle.
         StExec:  if (dec_illegal || insn_done) state_d = StNext;
         StNext:  state_d = run ? StFetch : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ram_rd_en = 1'b0;
      ram_addr  = '0;
      pc_inc    = 1'b0;
      insn_en   = '0;
      reg_num   = '0;
      illegal   = 1'b0;
      unique case (state_q)
         StFetch: begin
            ram_rd_en = 1'b1;
            ram_addr  = pc;
         end
         StExec: begin
            insn_en = dec_en;
            reg_num = insn_reg(ir_q);
            illegal = dec_illegal;
         end
         StNext:  pc_inc = 1'b1;
         default: ;
      endcase
   end

endmodule
